// File: rtl/evm_ballot_counter.sv
// Clocked ballot tally core: one ballot per armed session, candidate counters, turnout divider.
// Optional per-gender tally and gender validation enabled by defining EVM_GENDER_TALLY_EN.
module evm_ballot_counter #(
  parameter int NUM_CAND   = 3,
  parameter int CNT_W      = 8,
  parameter int ELECTORATE = 127,
  localparam int TOT_W     = CNT_W + $clog2(NUM_CAND),
  localparam int NUM_W     = TOT_W + 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      voting_en,
  input  logic                      cast,
  input  logic [NUM_CAND-1:0]       ballot_sel,
  input  logic                      gender_male,
  input  logic                      gender_female,
  output logic [NUM_CAND-1:0]       vote_led,
  output logic                      invalid,
  output logic [NUM_CAND*CNT_W-1:0] tally,
  output logic [TOT_W-1:0]          total,
  output logic [CNT_W-1:0]          male_cnt,
  output logic [CNT_W-1:0]          female_cnt,
  output logic [6:0]                turnout_pct,
  output logic                      pct_valid,
  output logic                      busy
);

  localparam int IDX_W  = $clog2(NUM_CAND);
  localparam int STEP_W = $clog2(NUM_W + 1);

  typedef enum logic [1:0] {IDLE, ARMED, CALC, DONE} state_t;

  state_t              state;
  logic                en_q;
  logic                en_qq;
  logic [CNT_W-1:0]    cnt [NUM_CAND];
  logic [NUM_W-1:0]    dvd;
  logic [TOT_W-1:0]    rem;
  logic [6:0]          quo;
  logic [STEP_W-1:0]   step;

  logic [IDX_W-1:0]    sel_idx;
  logic                sel_onehot;
  logic                gender_ok;
  logic                accept;
  logic [TOT_W:0]      shifted;
  logic                ge;

`ifndef EVM_GENDER_TALLY_EN
  logic gender_unused;
  assign gender_unused = gender_male | gender_female;
  assign male_cnt      = '0;
  assign female_cnt    = '0;
`endif

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (ballot_sel[i]) sel_idx = IDX_W'(i);
    end
    sel_onehot = (ballot_sel != '0) &&
                 ((ballot_sel & (ballot_sel - NUM_CAND'(1))) == '0);
`ifdef EVM_GENDER_TALLY_EN
    gender_ok = gender_male ^ gender_female;
`else
    gender_ok = 1'b1;
`endif
    accept = sel_onehot && (cnt[sel_idx] != '1) &&
             (total < TOT_W'(ELECTORATE)) && gender_ok;
  end

  always_comb begin
    tally = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      tally[i*CNT_W +: CNT_W] = cnt[i];
    end
  end

  // Restoring division step: dividend shifts out MSB-first, quotient bits shift in at LSB.
  assign shifted = {rem, dvd[NUM_W-1]};
  assign ge      = shifted >= (TOT_W+1)'(ELECTORATE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      en_q        <= 1'b0;
      en_qq       <= 1'b0;
      for (int unsigned i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
      total       <= '0;
      vote_led    <= '0;
      invalid     <= 1'b0;
      turnout_pct <= '0;
      pct_valid   <= 1'b1;
      busy        <= 1'b0;
      dvd         <= '0;
      rem         <= '0;
      quo         <= '0;
      step        <= '0;
`ifdef EVM_GENDER_TALLY_EN
      male_cnt    <= '0;
      female_cnt  <= '0;
`endif
    end else begin
      en_q  <= voting_en;
      en_qq <= en_q;
      case (state)
        IDLE: begin
          if (en_q && !en_qq) begin
            state    <= ARMED;
            busy     <= 1'b1;
            invalid  <= 1'b0;
            vote_led <= '0;
          end
        end
        ARMED: begin
          if (cast) begin
            if (accept) begin
              cnt[sel_idx] <= cnt[sel_idx] + CNT_W'(1);
              total        <= total + TOT_W'(1);
`ifdef EVM_GENDER_TALLY_EN
              if (gender_male)   male_cnt   <= male_cnt + CNT_W'(1);
              if (gender_female) female_cnt <= female_cnt + CNT_W'(1);
`endif
              vote_led  <= ballot_sel;
              dvd       <= NUM_W'(total + TOT_W'(1)) * NUM_W'(100);
              rem       <= '0;
              quo       <= '0;
              step      <= '0;
              pct_valid <= 1'b0;
              state     <= CALC;
            end else begin
              invalid  <= 1'b1;
              vote_led <= '0;
              busy     <= 1'b0;
              state    <= DONE;
            end
          end else if (!en_q) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CALC: begin
          if (step == STEP_W'(NUM_W)) begin
            turnout_pct <= quo;
            pct_valid   <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            dvd  <= {dvd[NUM_W-2:0], 1'b0};
            rem  <= TOT_W'(ge ? (shifted - (TOT_W+1)'(ELECTORATE)) : shifted);
            quo  <= {quo[5:0], ge};
            step <= step + STEP_W'(1);
          end
        end
        DONE: begin
          if (!en_q) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_evm_ballot_counter.sv
// Scoreboard bench for evm_ballot_counter: stimulus queues expected ballot outcomes,
// a negedge monitor pops them when a ballot completes (pct_valid or invalid rising).
module tb_evm_ballot_counter;
  logic        clk, rst_n, voting_en, cast, gender_male, gender_female;
  logic [2:0]  ballot_sel, vote_led;
  logic        invalid, pct_valid, busy;
  logic [23:0] tally;
  logic [9:0]  total;
  logic [7:0]  male_cnt, female_cnt;
  logic [6:0]  turnout_pct;

  typedef struct {
    logic        inv;
    logic [2:0]  led;
    logic [23:0] tally;
    logic [9:0]  total;
    logic [7:0]  male;
    logic [7:0]  female;
    logic [6:0]  pct;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned mt[3];
  int unsigned m_total, m_male, m_female, m_pct;
  logic        pv_prev, inv_prev;

  evm_ballot_counter #(.NUM_CAND(3), .CNT_W(8), .ELECTORATE(127)) dut (
    .clk(clk), .rst_n(rst_n), .voting_en(voting_en), .cast(cast),
    .ballot_sel(ballot_sel), .gender_male(gender_male), .gender_female(gender_female),
    .vote_led(vote_led), .invalid(invalid), .tally(tally), .total(total),
    .male_cnt(male_cnt), .female_cnt(female_cnt), .turnout_pct(turnout_pct),
    .pct_valid(pct_valid), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] model_tally();
    logic [7:0] a, b, c;
    a = mt[0][7:0];
    b = mt[1][7:0];
    c = mt[2][7:0];
    return {c, b, a};
  endfunction

  // Monitor: one scoreboard entry per completed ballot.
  initial begin
    exp_t e;
    pv_prev  = 1'b0;
    inv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && ((pct_valid === 1'b1 && pv_prev === 1'b0) ||
                             (invalid === 1'b1 && inv_prev === 1'b0))) begin
        chk("queue_has_entry", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("ev_invalid", invalid, e.inv);
          chk("ev_vote_led", vote_led, e.led);
          chk("ev_tally", tally, e.tally);
          chk("ev_total", total, e.total);
          chk("ev_male", male_cnt, e.male);
          chk("ev_female", female_cnt, e.female);
          chk("ev_pct", turnout_pct, e.pct);
          chk("ev_pct_valid", pct_valid, 1);
        end
      end
      pv_prev  = pct_valid;
      inv_prev = invalid;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; voting_en = 1'b0; cast = 1'b0; ballot_sel = '0;
    gender_male = 1'b0; gender_female = 1'b0;
    @(posedge clk); #1;
    chk("rst_tally", tally, 0);
    chk("rst_total", total, 0);
    chk("rst_male", male_cnt, 0);
    chk("rst_female", female_cnt, 0);
    chk("rst_vote_led", vote_led, 0);
    chk("rst_invalid", invalid, 0);
    chk("rst_pct", turnout_pct, 0);
    chk("rst_pct_valid", pct_valid, 1);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) mt[i] = 0;
    m_total = 0; m_male = 0; m_female = 0; m_pct = 0;
    q.delete();
  endtask

  task automatic arm();
    voting_en = 1'b1;
    @(posedge clk); #1;
    chk("arm_busy_early", busy, 0);
    @(posedge clk); #1;
    chk("arm_busy", busy, 1);
  endtask

  task automatic end_session();
    voting_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_cast(input logic [2:0] sel, input logic gm, input logic gf, output int lat);
    exp_t e;
    int   idx;
    bit   ok;
    idx = 0;
    for (int i = 0; i < 3; i++) if (sel[i]) idx = i;
    ok = ($countones(sel) == 1) && (mt[idx] < 255) && (m_total < 127);
`ifdef EVM_GENDER_TALLY_EN
    ok = ok && (gm != gf);
`endif
    if (ok) begin
      mt[idx]++;
      m_total++;
`ifdef EVM_GENDER_TALLY_EN
      if (gm) m_male++;
      if (gf) m_female++;
`endif
      m_pct = m_total * 100 / 127;
    end
    e.inv    = !ok;
    e.led    = ok ? sel : 3'b000;
    e.tally  = model_tally();
    e.total  = m_total[9:0];
    e.male   = m_male[7:0];
    e.female = m_female[7:0];
    e.pct    = m_pct[6:0];
    q.push_back(e);
    ballot_sel = sel; gender_male = gm; gender_female = gf; cast = 1'b1;
    @(posedge clk); #1;
    cast = 1'b0; ballot_sel = '0; gender_male = 1'b0; gender_female = 1'b0;
    if (ok) chk("pct_valid_drop", pct_valid, 0);
    lat = 0;
    while (busy === 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b0) chk("ballot_timeout", busy, 0);
  endtask

  task automatic session(input logic [2:0] sel, input logic gm, input logic gf);
    int lat;
    arm();
    do_cast(sel, gm, gf, lat);
    end_session();
  endtask

  initial begin
    int lat;
    int k;
    rst_n = 1'b0; voting_en = 1'b0; cast = 1'b0; ballot_sel = '0;
    gender_male = 1'b0; gender_female = 1'b0;
    do_reset();

    // First ballot: candidate 1, male; quotient latency NUM_W+1 = 18.
    arm();
    do_cast(3'b010, 1'b1, 1'b0, lat);
    chk("calc_latency", lat, 18);
    chk("first_tally", tally, 24'h000100);
    chk("first_total", total, 1);
    chk("first_pct", turnout_pct, 0);
    end_session();

    // Overvote rejected; a second cast in the same session is ignored.
    arm();
    do_cast(3'b011, 1'b0, 1'b1, lat);
    chk("reject_busy", busy, 0);
    cast = 1'b1; ballot_sel = 3'b100; gender_male = 1'b1;
    @(posedge clk); #1;
    cast = 1'b0; ballot_sel = '0; gender_male = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("second_cast_total", total, 1);
    chk("second_cast_invalid", invalid, 1);
    end_session();

    // Abandoned session: invalid stays 0.
    arm();
    voting_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abandon_busy", busy, 0);
    chk("abandon_invalid", invalid, 0);

    // Cast coincident with the arm event is ignored.
    voting_en = 1'b1;
    @(posedge clk); #1;
    cast = 1'b1; ballot_sel = 3'b001; gender_male = 1'b1;
    @(posedge clk); #1;
    cast = 1'b0; ballot_sel = '0; gender_male = 1'b0;
    chk("arm_cast_busy", busy, 1);
    chk("arm_cast_total", total, 1);
    do_cast(3'b001, 1'b0, 1'b1, lat);
    chk("after_arm_cast_total", total, 2);
    end_session();

    // voting_en held high: only the first of two casts counts.
    arm();
    do_cast(3'b100, 1'b1, 1'b0, lat);
    cast = 1'b1; ballot_sel = 3'b100; gender_male = 1'b1;
    @(posedge clk); #1;
    cast = 1'b0; ballot_sel = '0; gender_male = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("held_en_total", total, 3);
    end_session();
    session(3'b100, 1'b1, 1'b0);
    chk("rearm_total", total, 4);

    // Both gender switches set.
    session(3'b001, 1'b1, 1'b1);
`ifdef EVM_GENDER_TALLY_EN
    chk("gender_both_total", total, 4);
    chk("gender_both_invalid", invalid, 1);
`else
    chk("gender_both_total", total, 5);
    chk("gender_both_male", male_cnt, 0);
    chk("gender_both_female", female_cnt, 0);
`endif

    // Fill to 64 (50%), then to the electorate limit (100%), then overflow reject.
    k = 0;
    while (m_total < 64 && k < 200) begin
      session(3'b001 << (k % 3), k[0], ~k[0]);
      k++;
    end
    chk("half_total", total, 64);
    chk("half_pct", turnout_pct, 50);
    while (m_total < 127 && k < 400) begin
      session(3'b001 << (k % 3), k[0], ~k[0]);
      k++;
    end
    chk("full_total", total, 127);
    chk("full_pct", turnout_pct, 100);
    session(3'b010, 1'b1, 1'b0);
    chk("over_total", total, 127);
    chk("over_invalid", invalid, 1);
    chk("over_pct", turnout_pct, 100);

    // Reset in the middle of a division.
    do_reset();
    arm();
    cast = 1'b1; ballot_sel = 3'b010; gender_male = 1'b1;
    @(posedge clk); #1;
    cast = 1'b0; ballot_sel = '0; gender_male = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_calc_busy", busy, 1);
    chk("mid_calc_pct_valid", pct_valid, 0);
    do_reset();

    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/evm_ballot_counter.md
# evm_ballot_counter

Synchronous, parametrised vote-tally core for the electronic voting machine: one ballot per voter session, NUM_CAND candidate counters, optional per-gender turnout counters, one-hot/overvote validation, and a sequential divider producing turnout percentage against a fixed electorate size. It sits between the debounced voter-panel inputs (session enable, candidate switches, gender switches) and the display/LED layer, replacing the level-triggered combinational tally with a clocked FSM.

## Interface
- NUM_CAND, 3: number of candidates (2..16)
- CNT_W, 8: width of each candidate and gender counter
- ELECTORATE, 127: registered voters; divisor for turnout (1..2^TOT_W-1)
- Derived: TOT_W = CNT_W + $clog2(NUM_CAND); NUM_W = TOT_W + 7

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- voting_en  in  1  session enable from polling officer; rising edge arms one ballot
- cast  in  1  single-cycle ballot strobe from the voter panel
- ballot_sel  in  NUM_CAND  candidate switches; must be one-hot when cast is high
- gender_male  in  1  voter gender switch, male
- gender_female  in  1  voter gender switch, female
- vote_led  out  NUM_CAND  one-hot confirmation of the last accepted ballot
- invalid  out  1  last ballot of this session was rejected
- tally  out  NUM_CAND*CNT_W  packed candidate counters, candidate 0 in LSBs
- total  out  TOT_W  sum of all accepted ballots
- male_cnt  out  CNT_W  accepted ballots with gender_male
- female_cnt  out  CNT_W  accepted ballots with gender_female
- turnout_pct  out  7  floor(total*100/ELECTORATE), 0..100
- pct_valid  out  1  turnout_pct is current
- busy  out  1  high in ARMED, CALC

## Operation
- States: IDLE, ARMED, CALC, DONE.
- voting_en is registered once; arm event = sampled high while previous sample low.
- IDLE: arm event -> ARMED; clear invalid and vote_led. cast ignored.
- ARMED: on cast, ballot is accepted iff ballot_sel has exactly one bit set, selected counter < 2^CNT_W-1, total < ELECTORATE, and (with gender tally) exactly one of gender_male/gender_female is high.
  - Accepted: selected counter +1, total +1, matching gender counter +1, vote_led = ballot_sel, -> CALC.
  - Rejected: no counter changes, invalid = 1, vote_led = 0, -> DONE.
  - No cast: stay ARMED indefinitely; voting_en falling -> IDLE with no ballot (session abandoned, invalid stays 0).
- CALC: restoring divider, dividend total*100 (NUM_W bits), divisor ELECTORATE, one quotient bit per cycle; pct_valid = 0; then turnout_pct updated, pct_valid = 1, -> DONE. cast ignored.
- DONE: cast ignored; voting_en low (sampled) -> IDLE. A new arm requires voting_en to fall and rise again.
- Counters never wrap; saturation is enforced by rejection, not by clamping.
- Outputs vote_led/invalid hold until next arm event.

## Timing
- Reset values: all counters 0, total 0, vote_led 0, invalid 0, turnout_pct 0, pct_valid 1, busy 0, state IDLE.
- voting_en rise at edge k -> ARMED (busy=1) after edge k+1; cast first honoured at edge k+2.
- Accepted cast sampled at edge n: tally/total/gender/vote_led update at edge n; pct_valid low from edge n; turnout_pct valid after edge n+NUM_W+1.
- Rejected cast at edge n: invalid high after edge n, busy low.
- cast in the same cycle as the arm event: ignored.
- voting_en falling during CALC: division completes, then DONE -> IDLE next edge.
- rst_n low at any edge (including mid-CALC): all state to reset values at that edge; dominates every other input.

## Configuration
- EVM_GENDER_TALLY_EN defined: male_cnt/female_cnt counted; ballot with both or neither gender switch set is rejected (invalid).
- Undefined: gender inputs ignored, male_cnt/female_cnt tied to 0, no gender check; ports remain for pin compatibility.

## Test plan
- Reset, arm, cast ballot_sel=3'b010 with gender_male=1 -> tally[15:8]=1, total=1, male_cnt=1, vote_led=3'b010, after 18 cycles turnout_pct=0, pct_valid=1.
- Cast ballot_sel=3'b011 -> invalid=1, all counters unchanged; second cast in same session ignored.
- 64 accepted sessions (ELECTORATE=127) -> total=64, turnout_pct=50; at total=127 next valid ballot -> invalid=1, total stays 127, turnout_pct=100.
- Hold voting_en high, pulse cast twice -> only first counted; drop/raise voting_en -> next cast counted.
- Gender both set with EVM_GENDER_TALLY_EN -> invalid=1; without macro -> accepted, male_cnt=female_cnt=0.
- Assert rst_n=0 mid-CALC -> next cycle all counters 0, pct_valid=1, busy=0; cast arriving with arm edge ignored.
